// File: rtl/sha1_msg_padder.sv
// Byte-serial SHA-1 message padder. Packs bytes into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit big-endian message bit length.
module sha1_msg_padder #(
  parameter int CNT_W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [7:0]   IN_DATA,
  input  logic         IN_LAST,
  input  logic         IN_NULL,
  output logic         BLK_VALID,
  input  logic         BLK_READY,
  output logic [511:0] BLK_DATA,
  output logic         BLK_FIRST,
  output logic         BLK_LAST
);

  typedef enum logic [1:0] {FILL, PAD, EMIT, XTRA} state_t;

  state_t           state, state_nxt;
  logic [63:0][7:0] blk_buf;
  logic [5:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             first, p80, plen, last_q;
  logic             wrapped;
  logic [63:0]      bitlen;
  logic [63:0]      len_now;
  logic             in_xfer, is_null;

  assign in_xfer = IN_VALID && (state == FILL);
  assign is_null = IN_LAST && IN_NULL;
  assign len_now = 64'(cnt) << 3;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FILL;
    else       state <= state_nxt;
  end

  // NOTE: next-state is defaulted before the case so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: begin
        if (in_xfer) begin
          if (IN_LAST)           state_nxt = PAD;
          else if (idx == 6'd63) state_nxt = EMIT;
        end
      end
      PAD:  state_nxt = EMIT;
      EMIT: if (BLK_READY) state_nxt = plen ? XTRA : FILL;
      XTRA: state_nxt = EMIT;
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: all sequential state below uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the block buffer is reset along with the control, since BLK_DATA must read zero out of reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      blk_buf <= '0;
      idx     <= '0;
      cnt     <= '0;
      first   <= 1'b1;
      p80     <= 1'b0;
      plen    <= 1'b0;
      last_q  <= 1'b0;
      wrapped <= 1'b0;
      bitlen  <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_xfer) begin
            last_q  <= 1'b0;
            wrapped <= 1'b0;
            if (!is_null) begin
              blk_buf[idx] <= IN_DATA;
              idx          <= idx + 6'd1;
              cnt          <= cnt + CNT_W'(1);
              wrapped      <= (idx == 6'd63);
            end
          end
        end
        PAD: begin
          bitlen <= len_now;
          // A final byte that landed in position 63 leaves no room: marker and length both go to XTRA.
          if ((idx == 6'd0) && wrapped) begin
            p80    <= 1'b1;
            plen   <= 1'b1;
            last_q <= 1'b0;
          end else begin
            for (int i = 0; i < 64; i++) begin
              if (i == int'(idx))
                blk_buf[i[5:0]] <= 8'h80;
              else if (i > int'(idx))
                blk_buf[i[5:0]] <= ((i >= 56) && (idx <= 6'd55)) ? len_now[8*(63-i) +: 8] : 8'h00;
            end
            plen   <= (idx >= 6'd56);
            last_q <= (idx <= 6'd55);
          end
        end
        EMIT: begin
          if (BLK_READY) begin
            first <= 1'b0;
            if (last_q) begin
              cnt   <= '0;
              idx   <= '0;
              first <= 1'b1;
            end
          end
        end
        XTRA: begin
          blk_buf[0] <= p80 ? 8'h80 : 8'h00;
          for (int i = 1; i < 64; i++)
            blk_buf[i[5:0]] <= (i >= 56) ? bitlen[8*(63-i) +: 8] : 8'h00;
          p80    <= 1'b0;
          plen   <= 1'b0;
          last_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state == FILL);
  assign BLK_VALID = (state == EMIT);
  assign BLK_DATA  = blk_buf;
  assign BLK_FIRST = (state == EMIT) && first;
  assign BLK_LAST  = (state == EMIT) && last_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: directed test-plan messages plus
// randomized messages scored against a byte-queue padding model.
module tb_sha1_msg_padder;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    int           trig;  // >=0: transfer index that starts PAD; -1: follows previous accept; -2: unchecked
  } blk_t;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         IN_VALID, IN_LAST, IN_NULL;
  logic [7:0]   IN_DATA;
  logic         IN_READY;
  logic         BLK_VALID, BLK_FIRST, BLK_LAST;
  logic         BLK_READY = 1'b0;
  logic [511:0] BLK_DATA;

  int           n_checks = 0;
  int           n_fail   = 0;
  blk_t         exp_q[$];
  logic [511:0] got_q[$];
  longint       xfer_t[$];
  longint       acc_t = 0;
  int           rdy_mode = 0;
  int           stall_req = 0;
  int           stall_left = 0;
  bit           prev_valid = 0;
  bit           have_cur = 0;
  bit           rdy_chk = 0;
  blk_t         cur;

  sha1_msg_padder #(.CNT_W(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_LAST   (IN_LAST),
    .IN_NULL   (IN_NULL),
    .BLK_VALID (BLK_VALID),
    .BLK_READY (BLK_READY),
    .BLK_DATA  (BLK_DATA),
    .BLK_FIRST (BLK_FIRST),
    .BLK_LAST  (BLK_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Block sink: scores each presented block against the model, applies backpressure.
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_valid = 0;
      have_cur   = 0;
      rdy_chk    = 0;
      BLK_READY  = 1'b0;
    end else begin
      if (rdy_chk) begin
        check("in_ready_after_last", IN_READY, 1);
        rdy_chk = 0;
      end
      if (BLK_VALID) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", 1, 0);
            have_cur = 0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            if (cur.trig >= 0)
              check("rise_after_input", longint'($time) - 5, xfer_t[cur.trig] + 10);
            else if (cur.trig == -1)
              check("rise_after_accept", longint'($time) - 5, acc_t + 10);
            stall_left = stall_req;
            stall_req  = 0;
          end
        end
        if (have_cur) begin
          check("blk_data", BLK_DATA, cur.data);
          check("blk_first", BLK_FIRST, cur.first);
          check("blk_last", BLK_LAST, cur.last);
        end
        check("in_ready_low", IN_READY, 0);
        if (stall_left > 0) begin
          BLK_READY = 1'b0;
          stall_left--;
        end else if (rdy_mode != 0) begin
          BLK_READY = ($urandom_range(0, 2) != 0);
        end else begin
          BLK_READY = 1'b1;
        end
        prev_valid = !BLK_READY;
        if (BLK_READY) begin
          acc_t = longint'($time) + 5;
          got_q.push_back(BLK_DATA);
          if (have_cur && cur.last) rdy_chk = 1;
        end
      end else begin
        prev_valid = 0;
        BLK_READY  = 1'b0;
      end
    end
  end

  task automatic send_xfer(input logic [7:0] d, input logic l, input logic nu);
    int g = 0;
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = l;
    IN_NULL  = nu;
    while (!IN_READY && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 2000) check("in_ready_timeout", 0, 1);
    else xfer_t.push_back(longint'($time) + 5);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_NULL  = 1'b0;
  endtask

  // Model: classic SHA-1 padding on a byte queue, then cut into 64-byte blocks.
  task automatic send_msg(input bq_t m, input bit use_null, input bit gaps);
    int          n    = m.size();
    int          base = xfer_t.size();
    int          nx   = n + (use_null ? 1 : 0);
    int          nb;
    bit          xtra;
    bq_t         p    = m;
    logic [63:0] bl   = 64'(n) << 3;
    blk_t        b;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb   = p.size() / 64;
    xtra = (n % 64 >= 56) || ((n % 64 == 0) && (n > 0) && !use_null);
    for (int j = 0; j < nb; j++) begin
      b.data = '0;
      for (int i = 0; i < 64; i++) b.data[8*i +: 8] = p[64*j + i];
      b.first = (j == 0);
      b.last  = (j == nb - 1);
      if (j == nb - 1 && xtra)                        b.trig = -1;
      else if (j == nb - 1 || (xtra && j == nb - 2))  b.trig = base + nx - 1;
      else                                            b.trig = -2;
      exp_q.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      bit lst = (i == n - 1) && !use_null;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge CLK);
      send_xfer(m[i], lst, (gaps && !lst) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    if (use_null) send_xfer(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || BLK_VALID || !IN_READY) && g < 3000) begin
      @(negedge CLK);
      g++;
    end
    check("drain_timeout", g < 3000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, IN_READY, 1);
    check({tag, "_blk_valid"}, BLK_VALID, 0);
    check({tag, "_blk_data"}, BLK_DATA, 0);
    check({tag, "_blk_first"}, BLK_FIRST, 0);
    check({tag, "_blk_last"}, BLK_LAST, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t          m;
    logic [511:0] k_abc, k;
    int           lens[11] = '{0, 1, 55, 56, 63, 64, 65, 119, 120, 127, 128};

    k_abc = '0;
    k_abc[31:0]    = 32'h80636261;
    k_abc[511:504] = 8'h18;

    nRST = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; IN_LAST = 1'b0; IN_NULL = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    nRST = 1'b1;

    // "abc"
    got_q.delete();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 0);
    drain();
    check("abc_count", got_q.size(), 1);
    check("abc_block", got_q[0], k_abc);

    // zero-length message via null terminator
    got_q.delete();
    m.delete();
    send_msg(m, 1, 0);
    drain();
    k = '0; k[7:0] = 8'h80;
    check("empty_block", got_q[0], k);

    // 55 bytes: marker and length share one block
    got_q.delete();
    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send_msg(m, 0, 0);
    drain();
    k = '0;
    for (int i = 0; i < 55; i++) k[8*i +: 8] = 8'h41;
    k[447:440] = 8'h80; k[503:496] = 8'h01; k[511:504] = 8'hB8;
    check("len55_count", got_q.size(), 1);
    check("len55_block", got_q[0], k);

    // 56 bytes: length spills into a second block
    got_q.delete();
    m.push_back(8'h41);
    send_msg(m, 0, 0);
    drain();
    k = '0;
    for (int i = 0; i < 56; i++) k[8*i +: 8] = 8'h41;
    k[455:448] = 8'h80;
    check("len56_count", got_q.size(), 2);
    check("len56_block1", got_q[0], k);
    k = '0; k[503:496] = 8'h01; k[511:504] = 8'hC0;
    check("len56_block2", got_q[1], k);

    // 64 bytes, then "abc" back-to-back
    got_q.delete();
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_msg(m, 0, 0);
    k = '0;
    for (int i = 0; i < 64; i++) k[8*i +: 8] = m[i];
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 0);
    drain();
    check("len64_count", got_q.size(), 3);
    check("len64_block1", got_q[0], k);
    k = '0; k[7:0] = 8'h80; k[503:496] = 8'h02;
    check("len64_block2", got_q[1], k);
    check("len64_next_abc", got_q[2], k_abc);

    // backpressure: hold BLK_READY low for 10 cycles
    got_q.delete();
    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    stall_req = 10;
    send_msg(m, 0, 0);
    drain();
    check("stall_count", got_q.size(), 1);

    // reset after 30 bytes abandons the message
    got_q.delete();
    for (int i = 0; i < 30; i++) send_xfer(8'($urandom), 1'b0, 1'b0);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge CLK);
    nRST = 1'b1;
    repeat (5) @(negedge CLK);
    check("midreset_no_block", BLK_VALID, 0);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 0);
    drain();
    check("midreset_count", got_q.size(), 1);
    check("midreset_abc", got_q[0], k_abc);

    // randomized messages, random gaps and backpressure
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int  n;
      bit  un;
      n = ($urandom_range(0, 1) != 0) ? lens[$urandom_range(0, 10)] : int'($urandom_range(0, 140));
      un = (n == 0) || ($urandom_range(0, 3) == 0);
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, un, 1);
    end
    drain();
    check("random_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
